// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction FIFO that decouples the fetch stage from the issue stage
// Ports:
//   clk                                  rising-edge clock
//   reset                                asynchronous, active-low reset
//   flush                                synchronous mispredict flush; empties the queue in one cycle
//   enq_valid/enq_ready                  fetch-side handshake
//   enq_pc/enq_instr/enq_pred_taken      offered entry
//   deq_valid/deq_ready                  issue-side handshake
//   deq_pc/deq_instr/deq_pred_taken      head entry, zero while deq_valid is low
//   count                                current occupancy
// Build option: FETCH_QUEUE_BYPASS_EN forwards an offered entry straight to deq_* while empty.
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [PC_W-1:0]            enq_pc,
    input  logic [INSTR_W-1:0]         enq_instr,
    input  logic                       enq_pred_taken,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INSTR_W-1:0]         deq_instr,
    output logic                       deq_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic               mem_pt    [DEPTH];
    logic [IW:0]        wptr, rptr;
    logic               empty, full, do_enq, do_deq, wr, rd;

    assign empty     = wptr == rptr;
    assign full      = (wptr[IW-1:0] == rptr[IW-1:0]) && (wptr[IW] != rptr[IW]);
    assign enq_ready = ~full & ~flush;
    assign do_enq    = enq_valid & enq_ready;
    assign do_deq    = deq_valid & deq_ready;
    assign count     = CW'(wptr - rptr);

`ifdef FETCH_QUEUE_BYPASS_EN
    // While empty the offered entry is the head; if issue takes it, it never touches the array.
    assign deq_valid = ~flush & (~empty | enq_valid);
    assign wr        = do_enq & ~(empty & do_deq);
    assign rd        = do_deq & ~empty;
    always_comb begin
        deq_pc         = ~deq_valid ? '0 : empty ? enq_pc         : mem_pc[rptr[IW-1:0]];
        deq_instr      = ~deq_valid ? '0 : empty ? enq_instr      : mem_instr[rptr[IW-1:0]];
        deq_pred_taken = ~deq_valid ? '0 : empty ? enq_pred_taken : mem_pt[rptr[IW-1:0]];
    end
`else
    assign deq_valid = ~empty & ~flush;
    assign wr        = do_enq;
    assign rd        = do_deq;
    always_comb begin
        deq_pc         = deq_valid ? mem_pc[rptr[IW-1:0]]    : '0;
        deq_instr      = deq_valid ? mem_instr[rptr[IW-1:0]] : '0;
        deq_pred_taken = deq_valid ? mem_pt[rptr[IW-1:0]]    : 1'b0;
    end
`endif

    // The wrap bit falls out of the natural carry since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (IW+1)'(wr);
            rptr <= rptr + (IW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_pc[wptr[IW-1:0]]    <= enq_pc;
            mem_instr[wptr[IW-1:0]] <= enq_instr;
            mem_pt[wptr[IW-1:0]]    <= enq_pred_taken;
        end
    end
endmodule
